load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and request decode helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR
    } lsu_state_e;

    function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
        logic bad;
        if (write) begin
            bad = (funct3 != F3_SB) && (funct3 != F3_SH) && (funct3 != F3_SW);
        end else begin
            bad = (funct3 != F3_LB) && (funct3 != F3_LH) && (funct3 != F3_LW) &&
                  (funct3 != F3_LBU) && (funct3 != F3_LHU);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extract/extend load data and merge sub-word store data into a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data_o = rdata_i;
            F3_LBU:  load_data_o = {24'b0, byte_sel};
            F3_LHU:  load_data_o = {16'b0, half_sel};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        merge_data_o = rdata_i;
        case (funct3_i)
            F3_SB: merge_data_o[8*lane_i +: 8] = wdata_i[7:0];
            F3_SH: begin
                if (lane_i[1]) begin
                    merge_data_o[31:16] = wdata_i;
                end else begin
                    merge_data_o[15:0] = wdata_i;
                end
            end
            default: merge_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit with read-modify-write for sub-word stores.
// Optional misalignment faulting when LSU_MISALIGN_CHECK_EN is defined.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wd,
    output logic              mem_write,
    input  logic [31:0]       mem_rd
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;

    logic              accept;
    logic              misalign;
    logic              acc_err;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    // Misalignment decode keys off funct3[1:0]: 01 = halfword, 10 = word for both loads and stores.
`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        misalign = 1'b0;
    end
`endif

    always_comb begin
        accept  = req_valid && req_ready;
        acc_err = f3_illegal(req_write, req_funct3) || misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = ST_IDLE;
                    end else if (!req_write) begin
                        state_d = ST_RD;
                    end else if (req_funct3 == F3_SW) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:     state_d = ST_IDLE;
            ST_RMW_RD: state_d = ST_WR;
            ST_WR:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_write = (state_q == ST_WR);
    end

    lsu_lane_align u_lane_align (
        .rdata_i      (mem_rd),
        .lane_i       (addr_q[1:0]),
        .funct3_i     (f3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    // Only the low halfword of store data is kept; SW data goes straight into mem_wd at acceptance.
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        mem_wd_d     = mem_wd_q;
        resp_rdata_d = resp_rdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata[15:0];
                    f3_d    = req_funct3;
                    if (acc_err) begin
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_write && (req_funct3 == F3_SW)) begin
                        mem_wd_d = req_wdata;
                    end
                end
            end
            ST_RD: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
            end
            ST_RMW_RD: begin
                mem_wd_d = merge_data;
            end
            ST_WR: begin
                resp_rdata_d = '0;
                resp_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            mem_wd_q     <= '0;
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            mem_wd_q     <= mem_wd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        mem_adr    = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wd     = mem_wd_q;
        resp_rdata = resp_rdata_q;
        resp_valid = resp_valid_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected responses/writes come from a transaction-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_write;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_write  (mem_write),
        .mem_rd     (mem_rd)
    );

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          cyc = 0;
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    assign mem_rd = mem[mem_adr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_adr[7:2]] <= mem_wd;
            wr_count <= wr_count + 1;
        end
    end

    typedef struct {
        int          due;
        bit          st;
        bit          er;
        logic [31:0] rdata;
        logic [31:0] wadr;
        logic [31:0] wd;
    } exp_t;

    exp_t        q[$];
    int          acc_cyc;
    int          last_resp_cyc = -1;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        bit ew;
        bit er;
        if (resp_valid) begin
            last_resp_cyc = cyc;
            last_rdata    = resp_rdata;
            last_err      = err;
        end
        if (rst_n) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            ew = (q.size() > 0) && q[0].st && !q[0].er && (q[0].due - 1 == cyc);
            er = (q.size() == 0) || (q[0].due <= cyc);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
            chk("mem_write", {31'b0, mem_write}, {31'b0, ew});
            chk("req_ready", {31'b0, req_ready}, {31'b0, er});
            if (ew) begin
                chk("mem_adr", mem_adr, q[0].wadr);
                chk("mem_wd", mem_wd, q[0].wd);
                ref_mem[q[0].wadr[7:2]] = q[0].wd;
            end
            if (ev) begin
                chk("err", {31'b0, err}, {31'b0, q[0].er});
                chk("resp_rdata", resp_rdata, q[0].rdata);
                void'(q.pop_front());
            end
        end
    end

    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          lat;
        int          sh;
        bit          ill;
        bit          mis;
        exp_t        e;
        logic [31:0] word;
        logic [31:0] mask;
        logic [7:0]  b8;
        logic [15:0] h16;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
            return;
        end
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc - 1;

        ill = w ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        word    = ref_mem[a[7:2]];
        e.st    = w;
        e.er    = ill || mis;
        e.rdata = '0;
        e.wadr  = {a[31:2], 2'b00};
        e.wd    = '0;
        if (e.er) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            b8  = 8'(word >> (8 * a[1:0]));
            h16 = 16'(word >> (16 * a[1]));
            case (f3)
                3'd0: e.rdata = b8[7] ? (32'hFFFFFF00 | b8) : 32'(b8);
                3'd1: e.rdata = h16[15] ? (32'hFFFF0000 | h16) : 32'(h16);
                3'd2: e.rdata = word;
                3'd4: e.rdata = 32'(b8);
                default: e.rdata = 32'(h16);
            endcase
        end else begin
            lat = (f3 == 3'd2) ? 2 : 3;
            if (f3 == 3'd0) begin
                sh   = 8 * a[1:0];
                mask = 32'hFF << sh;
            end else if (f3 == 3'd1) begin
                sh   = 16 * a[1];
                mask = 32'hFFFF << sh;
            end else begin
                sh   = 0;
                mask = 32'hFFFFFFFF;
            end
            e.wd = (word & ~mask) | ((wd << sh) & mask);
        end
        e.due = cyc + lat - 1;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        issue(w, f3, a, wd);
        drain();
    endtask

    initial begin
        int          wc0;
        logic [31:0] saved;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h01010101 * i ^ 32'hA5A50000;
            ref_mem[i] = 32'h01010101 * i ^ 32'hA5A50000;
        end
        mem[0] = 32'h11223344; ref_mem[0] = 32'h11223344;
        mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
        mem[4] = 32'h0;        ref_mem[4] = 32'h0;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        rst_n = 1'b1;

        wc0 = wr_count;
        run(1'b0, 3'b000, 32'h5, 32'h0);
        chk("lb_pin", last_rdata, 32'hFFFFFFAA);
        chk("lb_lat", 32'(last_resp_cyc - acc_cyc), 32'd2);
        chk("lb_nowrite", 32'(wr_count - wc0), 32'd0);

        run(1'b0, 3'b101, 32'h6, 32'h0);
        chk("lhu_pin", last_rdata, 32'h00008899);
        run(1'b0, 3'b001, 32'h4, 32'h0);
        chk("lh_pin", last_rdata, 32'hFFFFAABB);

        for (int i = 4; i < 8; i++) begin
            run(1'b0, 3'b000, 32'(i), 32'h0);
            run(1'b0, 3'b100, 32'(i), 32'h0);
        end

        wc0 = wr_count;
        run(1'b1, 3'b000, 32'h7, 32'h12345678);
        chk("sb_lat", 32'(last_resp_cyc - acc_cyc), 32'd3);
        chk("sb_mem", mem[1], 32'h7899AABB);
        chk("sb_writes", 32'(wr_count - wc0), 32'd1);
        chk("sb_rdata", last_rdata, 32'd0);

        wc0 = wr_count;
        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", 32'(last_resp_cyc - acc_cyc), 32'd2);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        chk("sw_writes", 32'(wr_count - wc0), 32'd1);

        run(1'b1, 3'b001, 32'h12, 32'hCAFE1234);
        chk("sh_mem", mem[4], 32'h1234BEEF);

        // Back-to-back: second request must be taken in the response cycle of the first.
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        issue(1'b0, 3'b100, 32'h6, 32'h0);
        drain();
        chk("b2b_gap", 32'(last_resp_cyc - acc_cyc), 32'd2);

        wc0 = wr_count;
        run(1'b0, 3'b011, 32'h4, 32'h0);
        chk("ill_ld_err", {31'b0, last_err}, 32'd1);
        chk("ill_ld_lat", 32'(last_resp_cyc - acc_cyc), 32'd1);
        chk("ill_ld_rdata", last_rdata, 32'd0);
        run(1'b0, 3'b110, 32'h4, 32'h0);
        run(1'b0, 3'b111, 32'h4, 32'h0);
        run(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
        chk("ill_st_err", {31'b0, last_err}, 32'd1);
        run(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        chk("ill_nowrite", 32'(wr_count - wc0), 32'd0);

        run(1'b0, 3'b010, 32'h2, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw_mis_err", {31'b0, last_err}, 32'd1);
        chk("lw_mis_lat", 32'(last_resp_cyc - acc_cyc), 32'd1);
`else
        chk("lw_mis_data", last_rdata, 32'h11223344);
        chk("lw_mis_err", {31'b0, last_err}, 32'd0);
`endif
        run(1'b0, 3'b001, 32'h5, 32'h0);
        run(1'b1, 3'b001, 32'h1, 32'h0000BEEF);
        run(1'b0, 3'b010, 32'h0, 32'h0);

        saved = mem[4];
        wc0   = wr_count;
        issue(1'b1, 3'b001, 32'h10, 32'h00005555);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_mem_adr", mem_adr, 32'd0);
        chk("abort_mem_wd", mem_wd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
        chk("abort_mem", mem[4], saved);
        chk("abort_writes", 32'(wr_count - wc0), 32'd0);

        run(1'b0, 3'b010, 32'h10, 32'h0);
        chk("post_abort_lw", last_rdata, saved);

        for (int i = 0; i < 64; i++) begin
            chk("mem_final", mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
